wb_regfile: RTL and testbench

//   General-purpose register file of the 5-stage MIPS32 pipeline; the consuming end of the

---
 rtl/wb_regfile.sv | 60 ++++++
 tb/tb_wb_regfile.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MIPS32 general-purpose register file: one write port fed by write-back, two combinational
// read ports for decode, optional same-cycle write->read bypass, $0 hardwired to zero.
module wb_regfile #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              wr_en;

   // $0 is cleared by reset and never written, so it stays zero after the first reset.
   assign wr_en = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[waddr] <= wdata;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic              re,
                                                   input logic [ADDR_W-1:0] raddr);
      logic [DATA_W-1:0] data;
      data = '0;
      if (rst || !re || (raddr == '0)) begin
         data = '0;
      end else if (BYPASS_EN && we && (waddr == raddr)) begin
         data = wdata;
      end else begin
         data = regs_q[raddr];
      end
      return data;
   endfunction

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      rdata1 = read_port(re1, raddr1);
      rdata2 = read_port(re2, raddr2);
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: drives one vector per cycle into a bypassing and a
// non-bypassing instance and checks both read ports against a register model.
module tb_wb_regfile;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   typedef struct {
      string             name;
      logic              rst;
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic              re1;
      logic [ADDR_W-1:0] raddr1;
      logic              re2;
      logic [ADDR_W-1:0] raddr2;
   } vec_t;

   typedef struct {
      string             name;
      logic [DATA_W-1:0] b1;
      logic [DATA_W-1:0] b2;
      logic [DATA_W-1:0] n1;
      logic [DATA_W-1:0] n2;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst, we, re1, re2;
   logic [ADDR_W-1:0] waddr, raddr1, raddr2;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata1, rdata2, rdata1_nb, rdata2_nb;

   logic [DATA_W-1:0] model [DEPTH];
   vec_t              stim_q[$];
   exp_t              exp_q[$];
   int                n_vec  = 0;
   int                n_fail = 0;

   always #5 clk = ~clk;

   wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(1'b1)) dut_byp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
   );

   wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1_nb),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2_nb)
   );

   function automatic logic [DATA_W-1:0] model_read(input vec_t v, input logic re,
                                                    input logic [ADDR_W-1:0] ra,
                                                    input bit byp);
      if (v.rst || !re || ra == 0) return '0;
      if (byp && v.we && v.waddr == ra) return v.wdata;
      return model[ra];
   endfunction

   task automatic add(input string name, input logic r, input logic w,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic e1, input logic [ADDR_W-1:0] a1,
                      input logic e2, input logic [ADDR_W-1:0] a2);
      vec_t v;
      v.name = name; v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
      v.re1 = e1; v.raddr1 = a1; v.re2 = e2; v.raddr2 = a2;
      stim_q.push_back(v);
   endtask

   // Drive the next vector and push what both instances should return this cycle.
   task automatic apply_next();
      vec_t v;
      exp_t e;
      v = stim_q.pop_front();
      rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
      re1 = v.re1; raddr1 = v.raddr1; re2 = v.re2; raddr2 = v.raddr2;
      e.name = v.name;
      e.b1 = model_read(v, v.re1, v.raddr1, 1'b1);
      e.b2 = model_read(v, v.re2, v.raddr2, 1'b1);
      e.n1 = model_read(v, v.re1, v.raddr1, 1'b0);
      e.n2 = model_read(v, v.re2, v.raddr2, 1'b0);
      exp_q.push_back(e);
   endtask

   // Advance one clock edge and update the model with the vector that was presented.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else if (we && waddr != 0) begin
         model[waddr] = wdata;
      end
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      add("rst_hold",  1, 0, 0, 0,            1, 1, 1, 31);
      add("rst_rd",    0, 0, 0, 0,            1, 5, 1, 31);
      add("pre_w5",    0, 1, 5, 32'hDEADBEEF, 1, 5, 0, 5);
      add("w5_seen",   0, 0, 0, 0,            1, 5, 1, 5);
      add("rst_w5",    1, 0, 0, 0,            1, 5, 1, 5);
      add("post_rst5", 0, 0, 0, 0,            1, 5, 1, 5);
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      add("w8",      0, 1, 8,  32'h12345678, 0, 0, 0, 0);
      add("rd8_p2",  0, 0, 0,  0,            0, 0, 1, 8);
      add("w1",      0, 1, 1,  32'h00000001, 0, 0, 0, 0);
      add("w31",     0, 1, 31, 32'h80000000, 1, 1, 0, 0);
      add("rd1_31",  0, 0, 0,  0,            1, 31, 1, 1);
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      add("w9_old",   0, 1, 9, 32'h11111111, 0, 0, 0, 0);
      add("byp9",     0, 1, 9, 32'hA5A5A5A5, 1, 9, 1, 9);
      add("after9",   0, 0, 0, 0,            1, 9, 1, 9);
      add("byp_miss", 0, 1, 10, 32'h0BADF00D, 1, 9, 1, 10);
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   task automatic test_zero_reg();
      exp_t e;
      add("w0_same", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
      add("w0_next", 0, 0, 0, 0,            1, 0, 1, 0);
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   task automatic test_read_enable();
      exp_t e;
      add("re1_off",  0, 0, 0, 0,            0, 8, 1, 8);
      add("re2_off",  0, 1, 8, 32'h55AA55AA, 1, 8, 0, 8);
      add("both8",    0, 0, 0, 0,            1, 8, 1, 8);
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   task automatic test_reset_write();
      exp_t e;
      add("w3_pre",   0, 1, 3, 32'h000000AB, 0, 0, 0, 0);
      add("rst_w3",   1, 1, 3, 32'h00000077, 1, 3, 1, 3);
      add("post_w3",  0, 0, 0, 0,            1, 3, 1, 8);
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 60; i++) begin
         // Narrow address range so writes and reads collide often.
         add("b2b", 0, 1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), $urandom(),
             1'($urandom_range(0, 4) != 0), ADDR_W'($urandom_range(0, 7)),
             1'($urandom_range(0, 4) != 0), ADDR_W'($urandom_range(0, 7)));
      end
      while (stim_q.size() > 0) begin
         apply_next();
         @(negedge clk);
         e = exp_q.pop_front();
         n_vec++;
         if ({rdata1, rdata2, rdata1_nb, rdata2_nb} !== {e.b1, e.b2, e.n1, e.n2}) begin
            n_fail++;
            $display("FAIL %s: got %h %h %h %h want %h %h %h %h", e.name, rdata1, rdata2,
                     rdata1_nb, rdata2_nb, e.b1, e.b2, e.n1, e.n2);
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = 'x;
      @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_read_enable();
      test_reset_write();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
